afifo_wr_arb: RTL

Write-side arbiter for the async FIFO: it shares the single `fifo_top` write port between NREQ requesters in the write clock domain. It grants the port round-robin, holds each grant for a bounded burst, and throttles on FIFO full. It drives the push/data side of `fifo_if` and sits directly in front of `fifo_top`.

---
 rtl/afifo_pkg.sv | 20 ++
 rtl/afifo_rr_pick.sv | 26 ++
 rtl/afifo_wr_arb.sv | 88 ++++++++
 3 files changed

// File: rtl/afifo_pkg.sv
// Shared types and defaults for the async FIFO write-side arbiter.
// data_t is sized from the default DW; afifo_wr_arb overrides the width by parameter.
package afifo_pkg;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 8;
    localparam int MAX_BURST_DEF = 4;

    typedef logic [DW_DEF-1:0] data_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/afifo_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward from last+1.
module afifo_rr_pick
    import afifo_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    // Offset NREQ lands back on 'last', so a lone request from the previous owner still wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!valid && req[wrap_idx(int'(last), k, NREQ)]) begin
                valid  = 1'b1;
                winner = IW'(wrap_idx(int'(last), k, NREQ));
            end
        end
    end

endmodule

// File: rtl/afifo_wr_arb.sv
// Write-side arbiter sharing the fifo_top push port between NREQ requesters,
// with round-robin grants, bounded bursts and stall on full.
module afifo_wr_arb
    import afifo_pkg::*;
#(
    parameter  int NREQ      = NREQ_DEF,
    parameter  int DW        = DW_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int IW        = $clog2(NREQ),
    localparam int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic             wr_clk,
    input  logic             wr_rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] data_in,
    input  logic             full,
    output logic [NREQ-1:0]  ack,
    output logic             push,
    output logic [DW-1:0]    wdata,
    output logic [IW-1:0]    owner,
    output logic             busy,
    output logic [15:0]      push_cnt
);

    arb_state_e    state;
    logic [BW-1:0] burst_cnt;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          req_own;
    logic          burst_last;

    afifo_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .last   (owner),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // wdata follows the registered owner; requesters hold their slice stable until ack.
    always_comb begin
        req_own = 1'b0;
        wdata   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IW'(i)) begin
                req_own = req[i];
                if (state == GRANT) wdata = data_in[i*DW +: DW];
            end
        end
    end

    // Reset suppresses the push in the very cycle it is asserted.
    assign push       = (state == GRANT) & req_own & ~full & ~wr_rst;
    assign busy       = (state == GRANT);
    assign burst_last = (burst_cnt == BW'(MAX_BURST - 1));

    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = push & (owner == IW'(i));
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state     <= IDLE;
            owner     <= IW'(NREQ - 1);
            burst_cnt <= '0;
            push_cnt  <= '0;
        end else begin
            if (push && push_cnt != 16'hFFFF) push_cnt <= push_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= GRANT;
                        owner     <= pick_idx;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (push) burst_cnt <= burst_cnt + 1'b1;
                    if (!req_own || (push && burst_last)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
